regfile_wr_arb: RTL and testbench

- Arbiter and sequencer for the single write port of the 3-port core register file.
- Shares the port between three sources:
  - pipeline writeback (wb), top priority;
  - load returns (ld), buffered in a small FIFO;
  - auxiliary/debug writes (aux), req/ack handshake.
- Drives the register file write port (address_w, wr_data, we, ck_en_w) from a registered output stage.
- Reports load-pending hazards to decode.

---
 rtl/regfile_wr_arb.sv | 184 ++++++++++++++++++
 tb/tb_regfile_wr_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb
// Description : Write-port arbiter for the core register file. It shares the
//               port between writeback, a load-return FIFO and an aux
//               handshake, and drives the port from a registered stage.
//               Optional build macro: REGFILE_WR_ARB_ADDR_FILTER_EN
//               (drops unimplemented addresses, adds err_unimpl).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arb #(
   parameter int LD_DEPTH     = 2,
   parameter int AUX_MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst_a,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        wb_stall,
   input  logic        ld_valid,
   input  logic [4:0]  ld_addr,
   input  logic [31:0] ld_data,
   output logic        ld_full,
   input  logic        aux_req,
   input  logic [4:0]  aux_addr,
   input  logic [31:0] aux_data,
   output logic        aux_ack,
`ifdef REGFILE_WR_ARB_ADDR_FILTER_EN
   output logic        err_unimpl,
`endif
   input  logic [4:0]  rd_addr_a,
   input  logic [4:0]  rd_addr_b,
   output logic        ld_pend_hit,
   output logic [4:0]  address_w,
   output logic [31:0] wr_data,
   output logic        we,
   output logic        ck_en_w
);

   // Storage is sized for the largest legal depth; only LD_DEPTH slots are used.
   localparam int c_SLOTS = 4;

   logic [1:0]         r_wr_ptr;
   logic [1:0]         r_rd_ptr;
   logic [2:0]         r_count;
   logic [c_SLOTS-1:0] r_vld;
   logic [36:0]        r_mem [c_SLOTS];
   logic [3:0]         r_starve;
   logic               r_ld_src;

   logic        w_full;
   logic        w_nempty;
   logic        w_aux_hi;
   logic        w_gnt_wb;
   logic        w_gnt_aux;
   logic        w_gnt_ld;
   logic        w_push;
   logic        w_wr;
   logic [4:0]  w_sel_addr;
   logic [31:0] w_sel_data;
   logic        w_wb_ok;
   logic        w_ld_ok;
   logic        w_aux_ok;
   logic        w_hit;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(LD_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

`ifdef REGFILE_WR_ARB_ADDR_FILTER_EN
   function automatic logic addr_ok(input logic [4:0] a);
      return (a <= 5'd3) || ((a >= 5'd10) && (a <= 5'd15)) || (a >= 5'd26);
   endfunction

   assign w_wb_ok  = addr_ok(wb_addr);
   assign w_ld_ok  = addr_ok(ld_addr);
   assign w_aux_ok = addr_ok(aux_addr);

   always_ff @(posedge clk) begin
      if (rst_a) begin
         err_unimpl <= 1'b0;
      end else begin
         err_unimpl <= (w_gnt_wb && !w_wb_ok) || (w_gnt_aux && !w_aux_ok) ||
                       (ld_valid && !w_full && !w_ld_ok);
      end
   end
`else
   assign w_wb_ok  = 1'b1;
   assign w_ld_ok  = 1'b1;
   assign w_aux_ok = 1'b1;
`endif

   // Grants are masked during reset so nothing is popped or acknowledged.
   always_comb begin
      w_full     = (r_count == 3'(LD_DEPTH));
      w_nempty   = (r_count != 3'd0);
      w_aux_hi   = aux_req && (r_starve >= 4'(AUX_MAX_WAIT));
      w_gnt_wb   = !rst_a && wb_we;
      w_gnt_aux  = !rst_a && !wb_we && aux_req && (w_aux_hi || !w_nempty);
      w_gnt_ld   = !rst_a && !wb_we && !w_aux_hi && w_nempty;
      w_push     = !rst_a && ld_valid && !w_full && w_ld_ok;
      w_sel_addr = r_mem[r_rd_ptr][36:32];
      w_sel_data = r_mem[r_rd_ptr][31:0];
      if (w_gnt_wb) begin
         w_sel_addr = wb_addr;
         w_sel_data = wb_data;
      end else if (w_gnt_aux) begin
         w_sel_addr = aux_addr;
         w_sel_data = aux_data;
      end
      w_wr = (w_gnt_wb && w_wb_ok) || w_gnt_ld || (w_gnt_aux && w_aux_ok);
   end

   always_comb begin
      w_hit = r_ld_src && ((address_w == rd_addr_a) || (address_w == rd_addr_b));
      for (int i = 0; i < c_SLOTS; i++) begin
         if (r_vld[i] && ((r_mem[i][36:32] == rd_addr_a) || (r_mem[i][36:32] == rd_addr_b))) begin
            w_hit = 1'b1;
         end
      end
   end

   assign ld_full     = w_full;
   assign aux_ack     = w_gnt_aux;
   assign ld_pend_hit = w_hit;

   // Payload storage needs no reset; validity is tracked by r_vld and r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {ld_addr, ld_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst_a) begin
         r_wr_ptr  <= 2'd0;
         r_rd_ptr  <= 2'd0;
         r_count   <= 3'd0;
         r_vld     <= '0;
         r_starve  <= 4'd0;
         r_ld_src  <= 1'b0;
         wb_stall  <= 1'b0;
         address_w <= 5'd0;
         wr_data   <= 32'd0;
         we        <= 1'b0;
         ck_en_w   <= 1'b0;
      end else begin
         // Push and pop never target the same slot: push needs !full, pop needs !empty.
         if (w_push) begin
            r_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_gnt_ld) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_gnt_ld})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase

         wb_stall <= w_full;

         if (!aux_req || w_gnt_aux) begin
            r_starve <= 4'd0;
         end else if (r_starve != 4'd15) begin
            r_starve <= r_starve + 4'd1;
         end

         we       <= w_wr;
         ck_en_w  <= w_wr;
         r_ld_src <= w_gnt_ld;
         if (w_wr) begin
            address_w <= w_sel_addr;
            wr_data   <= w_sel_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arb
// Description : Scoreboard bench for regfile_wr_arb; expected writes are
//               queued at stimulus time and matched as the write port fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arb;

   logic        clk = 1'b0;
   logic        rst_a;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        ld_valid;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_full;
   logic        aux_req;
   logic [4:0]  aux_addr;
   logic [31:0] aux_data;
   logic        aux_ack;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic        ld_pend_hit;
   logic [4:0]  address_w;
   logic [31:0] wr_data;
   logic        we;
   logic        ck_en_w;
`ifdef REGFILE_WR_ARB_ADDR_FILTER_EN
   logic        err_unimpl;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   regfile_wr_arb #(.LD_DEPTH(2), .AUX_MAX_WAIT(8)) dut (
      .clk(clk), .rst_a(rst_a),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_full(ld_full),
      .aux_req(aux_req), .aux_addr(aux_addr), .aux_data(aux_data), .aux_ack(aux_ack),
`ifdef REGFILE_WR_ARB_ADDR_FILTER_EN
      .err_unimpl(err_unimpl),
`endif
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .ld_pend_hit(ld_pend_hit),
      .address_w(address_w), .wr_data(wr_data), .we(we), .ck_en_w(ck_en_w)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back('{a: a, d: d});
   endtask

   // Write-port monitor: every we pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (we === 1'b1) begin
         check("ck_en_w_on", {63'd0, ck_en_w}, 64'd1);
         if (exp_q.size() == 0) begin
            check("unexpected_wr", {63'd0, we}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", {59'd0, address_w}, {59'd0, e.a});
            check("wr_data", {32'd0, wr_data}, {32'd0, e.d});
         end
      end else begin
         check("ck_en_w_off", {63'd0, ck_en_w}, 64'd0);
      end
   end

   initial begin
      rst_a = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      aux_req = 1'b0; aux_addr = '0; aux_data = '0;
      rd_addr_a = 5'd31; rd_addr_b = 5'd31;

      repeat (3) step();
      settle();
      check("rst_we", {63'd0, we}, 64'd0);
      check("rst_addr", {59'd0, address_w}, 64'd0);
      check("rst_data", {32'd0, wr_data}, 64'd0);
      check("rst_ld_full", {63'd0, ld_full}, 64'd0);
      check("rst_wb_stall", {63'd0, wb_stall}, 64'd0);
      check("rst_aux_ack", {63'd0, aux_ack}, 64'd0);
      step(); rst_a = 1'b0;
      repeat (2) step();

      // Single writeback.
      step(); wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'hDEADBEEF;
      expect_wr(5'd12, 32'hDEADBEEF);
      step(); wb_we = 1'b0; settle();
      check("wb_we_next", {63'd0, we}, 64'd1);
      step(); settle();
      check("wb_we_after", {63'd0, we}, 64'd0);

      // Loads queue behind continuous writeback until the FIFO fills.
      step(); wb_we = 1'b1; wb_addr = 5'd27; wb_data = 32'd1; expect_wr(5'd27, 32'd1);
      ld_valid = 1'b1; ld_addr = 5'd1; ld_data = 32'h11;
      step(); wb_data = 32'd2; expect_wr(5'd27, 32'd2);
      ld_addr = 5'd2; ld_data = 32'h22; settle();
      check("full_after_1", {63'd0, ld_full}, 64'd0);
      step(); wb_data = 32'd3; expect_wr(5'd27, 32'd3); ld_valid = 1'b0; settle();
      check("full_after_2", {63'd0, ld_full}, 64'd1);
      check("stall_lag", {63'd0, wb_stall}, 64'd0);
      step(); wb_data = 32'd4; expect_wr(5'd27, 32'd4); settle();
      check("stall_set", {63'd0, wb_stall}, 64'd1);
      expect_wr(5'd1, 32'h11);
      expect_wr(5'd2, 32'h22);
      step(); wb_we = 1'b0; settle();
      check("full_during_pop", {63'd0, ld_full}, 64'd1);
      step(); settle();
      check("full_cleared", {63'd0, ld_full}, 64'd0);
      repeat (3) step();
      settle();
      check("stall_cleared", {63'd0, wb_stall}, 64'd0);

      // Aux starvation: FIFO kept non-empty, aux wins after AUX_MAX_WAIT cycles.
      for (int k = 0; k < 8; k++) expect_wr(5'd3, 32'(k));
      expect_wr(5'd26, 32'hA5A5A5A5);
      expect_wr(5'd3, 32'd8);
      step(); ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'd0;
      for (int k = 1; k <= 8; k++) begin
         step(); ld_data = 32'(k);
         aux_req = 1'b1; aux_addr = 5'd26; aux_data = 32'hA5A5A5A5; settle();
         check("aux_wait", {63'd0, aux_ack}, 64'd0);
      end
      step(); ld_valid = 1'b0; settle();
      check("aux_grant", {63'd0, aux_ack}, 64'd1);
      step(); aux_req = 1'b0; settle();
      check("aux_pulse", {63'd0, aux_ack}, 64'd0);
      repeat (4) step();

      // Pending-load hazard on r14.
      rd_addr_a = 5'd14; rd_addr_b = 5'd7;
      step(); wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h99; expect_wr(5'd10, 32'h99);
      ld_valid = 1'b1; ld_addr = 5'd14; ld_data = 32'h14; settle();
      check("hit_not_queued", {63'd0, ld_pend_hit}, 64'd0);
      step(); ld_valid = 1'b0; wb_data = 32'h9A; expect_wr(5'd10, 32'h9A);
      expect_wr(5'd14, 32'h14); settle();
      check("hit_queued", {63'd0, ld_pend_hit}, 64'd1);
      step(); wb_we = 1'b0; settle();
      check("hit_popping", {63'd0, ld_pend_hit}, 64'd1);
      step(); settle();
      check("hit_inflight", {63'd0, ld_pend_hit}, 64'd1);
      step(); settle();
      check("hit_done", {63'd0, ld_pend_hit}, 64'd0);
      rd_addr_a = 5'd13; rd_addr_b = 5'd13;
      step(); ld_valid = 1'b1; ld_addr = 5'd14; ld_data = 32'h15; expect_wr(5'd14, 32'h15);
      for (int k = 0; k < 3; k++) begin
         settle();
         check("nohit_r13", {63'd0, ld_pend_hit}, 64'd0);
         step(); ld_valid = 1'b0;
      end
      repeat (2) step();

      // Reset with two queued loads and aux pending.
      rd_addr_a = 5'd11; rd_addr_b = 5'd31;
      step(); wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'd1; expect_wr(5'd10, 32'd1);
      ld_valid = 1'b1; ld_addr = 5'd11; ld_data = 32'h40;
      step(); wb_data = 32'd2; expect_wr(5'd10, 32'd2);
      ld_addr = 5'd12; ld_data = 32'h50;
      step(); wb_we = 1'b0; ld_valid = 1'b0;
      aux_req = 1'b1; aux_addr = 5'd26; aux_data = 32'h77; rst_a = 1'b1; settle();
      check("rst_mid_ack", {63'd0, aux_ack}, 64'd0);
      check("rst_mid_hit", {63'd0, ld_pend_hit}, 64'd1);
      step(); rst_a = 1'b0; aux_req = 1'b0; settle();
      check("post_rst_we", {63'd0, we}, 64'd0);
      check("post_rst_ack", {63'd0, aux_ack}, 64'd0);
      check("post_rst_full", {63'd0, ld_full}, 64'd0);
      check("post_rst_hit", {63'd0, ld_pend_hit}, 64'd0);
      check("post_rst_stall", {63'd0, wb_stall}, 64'd0);
      repeat (5) step();

`ifdef REGFILE_WR_ARB_ADDR_FILTER_EN
      rd_addr_a = 5'd5;
      step(); ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'h55;
      step(); ld_valid = 1'b0; settle();
      check("flt_ld_err", {63'd0, err_unimpl}, 64'd1);
      check("flt_ld_nohit", {63'd0, ld_pend_hit}, 64'd0);
      step(); aux_req = 1'b1; aux_addr = 5'd20; aux_data = 32'h20; settle();
      check("flt_aux_ack", {63'd0, aux_ack}, 64'd1);
      step(); aux_req = 1'b0; settle();
      check("flt_aux_err", {63'd0, err_unimpl}, 64'd1);
      repeat (3) step();
`endif

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
